// File: rtl/confetti_pkg.sv
// Shared types and constants for the confetti particle overlay.
package confetti_pkg;

  localparam int unsigned CoordW = 10;

  typedef struct packed {
    logic [CoordW-1:0] rowstart;
    logic [CoordW-1:0] colstart;
  } confetti_struct;

  typedef enum logic {
    StIdle,
    StUpdate
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Taps 16,14,13,11 as a mask over bits [15:0].
  localparam logic [15:0] LfsrTaps = 16'hB400;

endpackage

// File: rtl/confetti_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; never reaches all-zero from the seed.
module confetti_lfsr
  import confetti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic feedback;

  always_comb begin
    feedback = ^(value & LfsrTaps);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LfsrSeed;
    end else begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/confetti_engine.sv
// Falling confetti overlay: per-pixel hit test plus a one-particle-per-cycle
// position sweep started by each frame tick.
module confetti_engine
  import confetti_pkg::*;
#(
  parameter int unsigned NUM_CONFETTI = 51,
  parameter int unsigned SIZE         = 5,
  parameter int unsigned SCREEN_ROWS  = 480,
  parameter int unsigned SCREEN_COLS  = 640,
  parameter int unsigned FALL_STEP    = 2,
  parameter int unsigned COORD_W      = CoordW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic               isconfetti,
  output logic               busy
);

  localparam int unsigned IdxW    = (NUM_CONFETTI > 1) ? $clog2(NUM_CONFETTI) : 1;
  localparam int unsigned RowSpan = SCREEN_ROWS - SIZE;
  localparam int unsigned ColSpan = SCREEN_COLS - SIZE;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  confetti_struct    particles_q [NUM_CONFETTI];
  confetti_struct    upd;
  logic [15:0]       lfsr_value;
  logic [COORD_W:0]  row_sum;
  logic [COORD_W-1:0] rand_col;
  logic              hit;
  logic [COORD_W:0]  row_end, col_end;

  confetti_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy    = (state_q == StUpdate);
    unique case (state_q)
      StIdle: begin
        if (frame_tick && enable) begin
          state_d = StUpdate;
          idx_d   = '0;
        end
      end
      StUpdate: begin
        if (idx_q == IdxW'(NUM_CONFETTI - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // New position for the particle selected by idx_q; sum is one bit wider so it cannot wrap.
  always_comb begin
    upd      = particles_q[idx_q];
    row_sum  = {1'b0, upd.rowstart} + (COORD_W+1)'(FALL_STEP);
    rand_col = lfsr_value[COORD_W-1:0];
    if (row_sum <= (COORD_W+1)'(RowSpan)) begin
      upd.rowstart = row_sum[COORD_W-1:0];
    end else begin
      upd.rowstart = '0;
      upd.colstart = (rand_col < COORD_W'(ColSpan)) ? rand_col
                                                    : rand_col - COORD_W'(ColSpan);
    end
  end

  always_comb begin
    hit     = 1'b0;
    row_end = '0;
    col_end = '0;
    for (int i = 0; i < NUM_CONFETTI; i++) begin
      row_end = {1'b0, particles_q[i].rowstart} + (COORD_W+1)'(SIZE);
      col_end = {1'b0, particles_q[i].colstart} + (COORD_W+1)'(SIZE);
      if ((row >= particles_q[i].rowstart) && ({1'b0, row} < row_end) &&
          (col >= particles_q[i].colstart) && ({1'b0, col} < col_end)) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      isconfetti <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      isconfetti <= enable && hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CONFETTI; i++) begin
        particles_q[i].rowstart <= COORD_W'((i * 37) % RowSpan);
        particles_q[i].colstart <= COORD_W'((i * 61) % ColSpan);
      end
    end else if (state_q == StUpdate) begin
      for (int i = 0; i < NUM_CONFETTI; i++) begin
        if (idx_q == IdxW'(i)) begin
          particles_q[i] <= upd;
        end
      end
    end
  end

endmodule
